// File: rtl/fft32_pkg.sv
// fft32_pkg: shared constants and FSM encoding for the 32-point FFT twiddle stage
package fft32_pkg;
   localparam int N = 32;
   localparam int NUM_BFLY = 16;
   localparam int TW_FRAC = 6;
   localparam int NUM_STAGES = 5;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/fft32_cmul_pipe.sv
// fft32_cmul_pipe: 3-stage complex multiply by a Q1.6 twiddle with stall enable
// FFT32_TW_SAT_EN selects saturating narrowing instead of two's-complement wrap.
module fft32_cmul_pipe
   import fft32_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int TW_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_re,
   input  logic signed [DATA_WIDTH-1:0] in_im,
   input  logic signed [TW_WIDTH-1:0]   w_re,
   input  logic signed [TW_WIDTH-1:0]   w_im,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_re,
   output logic [DATA_WIDTH-1:0]        out_im
);
   localparam int PW = DATA_WIDTH + TW_WIDTH;
   localparam int SW = PW + 1;
   localparam logic signed [SW-1:0] RND = SW'(2 ** (TW_FRAC - 1));
   logic v1, v2;
   logic signed [DATA_WIDTH-1:0] a_re, a_im;
   logic signed [TW_WIDTH-1:0] b_re, b_im;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [SW-1:0] s_re, s_im;
   logic [DATA_WIDTH-1:0] n_re, n_im;
`ifdef FFT32_TW_SAT_EN
   localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);
   always_comb begin
      s_re = (SW'(p_rr) - SW'(p_ii) + RND) >>> TW_FRAC;
      s_im = (SW'(p_ri) + SW'(p_ir) + RND) >>> TW_FRAC;
      n_re = s_re > MAXV ? MAXV[DATA_WIDTH-1:0] : s_re < MINV ? MINV[DATA_WIDTH-1:0] : s_re[DATA_WIDTH-1:0];
      n_im = s_im > MAXV ? MAXV[DATA_WIDTH-1:0] : s_im < MINV ? MINV[DATA_WIDTH-1:0] : s_im[DATA_WIDTH-1:0];
   end
`else
   always_comb begin
      s_re = (SW'(p_rr) - SW'(p_ii) + RND) >>> TW_FRAC;
      s_im = (SW'(p_ri) + SW'(p_ir) + RND) >>> TW_FRAC;
      n_re = DATA_WIDTH'(s_re);
      n_im = DATA_WIDTH'(s_im);
   end
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         out_valid <= 1'b0;
         a_re <= '0;
         a_im <= '0;
         b_re <= '0;
         b_im <= '0;
         p_rr <= '0;
         p_ii <= '0;
         p_ri <= '0;
         p_ir <= '0;
         out_re <= '0;
         out_im <= '0;
      end else if (en) begin
         v1 <= in_valid;
         a_re <= in_re;
         a_im <= in_im;
         b_re <= w_re;
         b_im <= w_im;
         v2 <= v1;
         p_rr <= PW'(a_re) * PW'(b_re);
         p_ii <= PW'(a_im) * PW'(b_im);
         p_ri <= PW'(a_re) * PW'(b_im);
         p_ir <= PW'(a_im) * PW'(b_re);
         out_valid <= v2;
         out_re <= n_re;
         out_im <= n_im;
      end
   end
endmodule

// File: rtl/fft32_twiddle_stage.sv
// fft32_twiddle_stage: sequences W32^k per butterfly and multiplies the lower-leg stream
// Optional macro FFT32_TW_SAT_EN makes the product narrowing saturate.
module fft32_twiddle_stage
   import fft32_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int TW_WIDTH = 8,
   parameter int ROM_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [2:0]                      stage,
   input  logic [NUM_BFLY*ROM_WIDTH-1:0]   w_re_flat,
   input  logic [NUM_BFLY*ROM_WIDTH-1:0]   w_im_flat,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH-1:0]           in_re,
   input  logic [DATA_WIDTH-1:0]           in_im,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_WIDTH-1:0]           out_re,
   output logic [DATA_WIDTH-1:0]           out_im,
   output logic                            busy,
   output logic                            done
);
   state_t state, state_nx;
   logic [2:0] stage_q;
   logic [3:0] in_cnt, out_cnt, k;
   logic stall, in_acc, out_acc;
   logic signed [TW_WIDTH-1:0] w_re, w_im;
   assign stall = out_valid && !out_ready;
   assign in_ready = state == RUN && !stall;
   assign in_acc = in_valid && in_ready;
   assign out_acc = out_valid && out_ready;
   assign busy = state != IDLE;
   assign done = state == DRAIN && out_acc && out_cnt == 4'(NUM_BFLY - 1);
   // butterfly b within its group of 16>>stage, scaled up to the W32 index
   assign k = (in_cnt & (4'hF >> stage_q)) << stage_q;
   assign w_re = w_re_flat[int'(k) * ROM_WIDTH +: TW_WIDTH];
   assign w_im = w_im_flat[int'(k) * ROM_WIDTH +: TW_WIDTH];
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE && start ? RUN :
                 state == RUN && in_acc && in_cnt == 4'(NUM_BFLY - 1) ? DRAIN :
                 done ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         stage_q <= '0;
         in_cnt <= '0;
         out_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            stage_q <= stage > 3'(NUM_STAGES - 1) ? 3'(NUM_STAGES - 1) : stage;
            in_cnt <= '0;
            out_cnt <= '0;
         end else begin
            if (in_acc) in_cnt <= in_cnt + 4'd1;
            if (out_acc) out_cnt <= out_cnt + 4'd1;
         end
      end
   end
   fft32_cmul_pipe #(.DATA_WIDTH(DATA_WIDTH), .TW_WIDTH(TW_WIDTH)) u_cmul (
      .clk(clk),
      .rst_n(rst_n),
      .en(!stall),
      .in_valid(in_acc),
      .in_re(in_re),
      .in_im(in_im),
      .w_re(w_re),
      .w_im(w_im),
      .out_valid(out_valid),
      .out_re(out_re),
      .out_im(out_im)
   );
endmodule
